// File: rtl/dma_timing_control.sv
// dma_timing_control: DREQ arbitration, HRQ/HLDA handshake and per-transfer strobe/pulse sequencing for a 4-channel DMA.
module dma_timing_control #(
    parameter int CHANNELS = 4,
    parameter int ADDRESSWIDTH = 16,
    parameter int DATAWIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [CHANNELS-1:0]     DREQ,
    input  logic                    HLDA,
    input  logic                    EOP_N_IN,
    input  logic [DATAWIDTH-1:0]    commandReg,
    input  logic [6*CHANNELS-1:0]   modeRegFlat,
    input  logic [ADDRESSWIDTH-1:0] temporaryWordCountReg,
    output logic                    HRQ,
    output logic [CHANNELS-1:0]     DACK,
    output logic                    AEN,
    output logic                    ADSTB,
    output logic                    MEMR_N,
    output logic                    MEMW_N,
    output logic                    IOR_N_OUT,
    output logic                    IOW_N_OUT,
    output logic                    EOP_N,
    output logic                    loadAddr,
    output logic                    incrTemporaryAddressReg,
    output logic                    decrTemporaryWordCountReg,
    output logic                    updateCurrentAddressReg,
    output logic                    updateCurrentWordCountReg,
    output logic                    intEOP,
    output logic                    programCondition
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} stateT;
    stateT state, stateNext;
    logic [CW-1:0] ch, lastCh, winner, pick;
    logic tc, eopSeen, anyEligible, inXfer, exitS4, readPhase, writePhase;
    logic [CHANNELS-1:0] eligible;
    logic [1:0] typeOf [CHANNELS];
    logic [1:0] modeOf [CHANNELS];
    logic [1:0] chType, chMode;
    logic unusedBits;
    for (genvar i = 0; i < CHANNELS; i++) begin : genChan
        assign typeOf[i] = modeRegFlat[6*i +: 2];
        assign modeOf[i] = modeRegFlat[6*i+4 +: 2];
        assign eligible[i] = DREQ[i] && modeOf[i] != 2'b11;
    end
    assign unusedBits = ^{commandReg, modeRegFlat};
    assign anyEligible = |eligible;
    assign chType = typeOf[ch];
    assign chMode = modeOf[ch];
    assign inXfer = state == S1 || state == S2 || state == S3 || state == S4;
    assign exitS4 = tc || eopSeen || chMode == 2'b01 || commandReg[2] || (chMode == 2'b00 && !DREQ[ch]);
    // Scan from highest to lowest search position so the first position in search order wins.
    always_comb begin
        winner = '0;
        pick = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            pick = commandReg[4] ? CW'((int'(lastCh) + 1 + k) % CHANNELS) : CW'(k);
            if (eligible[pick]) winner = pick;
        end
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= SI;
            ch <= '0;
            lastCh <= CW'(CHANNELS - 1);
            tc <= 1'b0;
            eopSeen <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == S0 && stateNext == S1) begin
                ch <= winner;
                lastCh <= winner;
            end
            if (stateNext == SI) begin
                tc <= 1'b0;
                eopSeen <= 1'b0;
            end else begin
                if (state == S3) tc <= temporaryWordCountReg == '0;
                if (inXfer && !EOP_N_IN) eopSeen <= 1'b1;
            end
        end
    end
    always_comb begin
        stateNext = state;
        case (state)
            SI: stateNext = (!commandReg[2] && anyEligible) ? S0 : SI;
            S0: stateNext = !anyEligible ? SI : HLDA ? S1 : S0;
            S1: stateNext = HLDA ? S2 : SI;
            S2: stateNext = HLDA ? S3 : SI;
            S3: stateNext = HLDA ? S4 : SI;
            S4: stateNext = exitS4 ? SI : S1;
            default: stateNext = SI;
        endcase
        readPhase = state == S2 || state == S3;
        writePhase = state == S3;
        HRQ = state != SI;
        AEN = inXfer;
        DACK = inXfer ? CHANNELS'(1) << ch : '0;
        ADSTB = state == S1;
        loadAddr = state == S1;
        MEMR_N = !(readPhase && chType == 2'b10);
        IOR_N_OUT = !(readPhase && chType == 2'b01);
        IOW_N_OUT = !(writePhase && chType == 2'b10);
        MEMW_N = !(writePhase && chType == 2'b01);
        incrTemporaryAddressReg = state == S3;
        decrTemporaryWordCountReg = state == S3;
        updateCurrentAddressReg = state == S4;
        updateCurrentWordCountReg = state == S4;
        intEOP = state == S4 && (tc || eopSeen);
        EOP_N = !intEOP;
        programCondition = state == SI && !HLDA;
    end
endmodule
